dct_2d_top: RTL and testbench

//  8x8 2-D DCT-II engine for the JPEG compression datapath (between level shift and quantiser).

---
 rtl/dct_pkg.sv | 39 +++
 rtl/dct_2d_top_dct_1d.sv | 49 ++++
 rtl/dct_2d_top.sv | 126 ++++++++++++
 tb/tb_dct_2d_top.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/dct_pkg.sv
// Shared constants for the 8x8 2-D DCT: widths, coefficient table, rounding and saturation.
// Consumers honour the DCT_APPROX_EN build macro for product truncation.
package dct_pkg;

    localparam int SIZE            = 8;
    localparam int APPROX_BITS_ST1 = 4;
    localparam int APPROX_BITS_ST2 = 8;
    localparam int SIZE_MULT       = SIZE + 6;
    localparam int SIZE_OUT        = SIZE + 2;
    localparam int SIZE_FINAL      = SIZE + 4;
    localparam int COEF_W          = 6;
    localparam int SIZE_MULT2      = SIZE_OUT + COEF_W;
    localparam int ROUND           = 32;
    localparam int SHIFT           = 6;

    localparam logic signed [SIZE_FINAL-1:0] SAT_MAX = SIZE_FINAL'(1023);
    localparam logic signed [SIZE_FINAL-1:0] SAT_MIN = SIZE_FINAL'(-1024);

    // C[k][n] = round(32*ck*cos((2n+1)k*pi/16))
    localparam int COEF [8][8] = '{
        '{ 23,  23,  23,  23,  23,  23,  23,  23},
        '{ 31,  27,  18,   6,  -6, -18, -27, -31},
        '{ 30,  12, -12, -30, -30, -12,  12,  30},
        '{ 27,  -6, -31, -18,  18,  31,   6, -27},
        '{ 23, -23, -23,  23,  23, -23, -23,  23},
        '{ 18, -31,   6,  27, -27,  -6,  31, -18},
        '{ 12, -30,  30, -12, -12,  30, -30,  12},
        '{  6, -18,  27, -31,  31, -27,  18,  -6}
    };

    function automatic logic signed [SIZE_FINAL-2:0] saturate(
        input logic signed [SIZE_FINAL-1:0] v
    );
        if (v > SAT_MAX) return SAT_MAX[SIZE_FINAL-2:0];
        if (v < SAT_MIN) return SAT_MIN[SIZE_FINAL-2:0];
        return v[SIZE_FINAL-2:0];
    endfunction

endpackage

// File: rtl/dct_2d_top_dct_1d.sv
// Combinational 8-point DCT-II: y[k] = (sum_n x[n]*C[k][n] + 32) >>> 6.
// With DCT_APPROX_EN defined, approx=1 clears APPROX_BITS LSBs of every product.
module dct_1d
    import dct_pkg::*;
#(
    parameter int IN_W        = 8,
    parameter int PROD_W      = 14,
    parameter int OUT_W       = 10,
    parameter int APPROX_BITS = 4
) (
    input  logic signed [IN_W-1:0]  x [8],
    input  logic                    approx,
    output logic signed [OUT_W-1:0] y [8]
);

    localparam int ACC_W = PROD_W + 3;

    logic signed [PROD_W-1:0] prod [8][8];
    logic signed [ACC_W-1:0]  acc  [8];

`ifdef DCT_APPROX_EN
    localparam logic [PROD_W-1:0] MASK = ~PROD_W'((1 << APPROX_BITS) - 1);
`else
    logic unused_approx;
    assign unused_approx = approx;
`endif

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            for (int n = 0; n < 8; n++) begin
                prod[k][n] = PROD_W'(x[n]) * PROD_W'(COEF[k][n]);
`ifdef DCT_APPROX_EN
                if (approx) prod[k][n] = prod[k][n] & MASK;
`endif
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            acc[k] = ACC_W'(ROUND);
            for (int n = 0; n < 8; n++) begin
                acc[k] = acc[k] + ACC_W'(prod[k][n]);
            end
            y[k] = OUT_W'(acc[k] >>> SHIFT);
        end
    end

endmodule

// File: rtl/dct_2d_top.sv
// 8x8 2-D DCT: row DCT into a ping-pong transpose buffer, then column DCT into a shadow/output bank.
// Build macro DCT_APPROX_EN enables per-stage product truncation selected by approx_en.
module dct_2d_top
    import dct_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         dct_en,
    input  logic signed [SIZE-1:0]       data_in [8],
    input  logic [1:0]                   approx_en,
    output logic signed [SIZE_FINAL-2:0] data_out [8][8],
    output logic                         dct_done
);

    logic       fill_act, col_act, wbank, rbank;
    logic [2:0] row_cnt, col_cnt;
    logic       start, wr, launch, st1_approx, st2_approx;

    logic signed [SIZE_OUT-1:0]   tbuf    [2][8][8];
    logic signed [SIZE_FINAL-2:0] shadow  [8][8];
    logic signed [SIZE_OUT-1:0]   row_res [8];
    logic signed [SIZE_OUT-1:0]   col_in  [8];
    logic signed [SIZE_FINAL-1:0] col_res [8];

    assign start  = dct_en && !fill_act;
    assign wr     = start || fill_act;
    assign launch = wr && (row_cnt == 3'd7);

`ifdef DCT_APPROX_EN
    logic [1:0] approx_q;
    logic       approx2_q;

    // Stage 1 uses the live value at E0, the latched copy afterwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            approx_q  <= 2'b00;
            approx2_q <= 1'b0;
        end else begin
            if (start)  approx_q  <= approx_en;
            if (launch) approx2_q <= approx_q[1];
        end
    end

    assign st1_approx = start ? approx_en[0] : approx_q[0];
    assign st2_approx = approx2_q;
`else
    logic unused_approx;
    assign unused_approx = ^approx_en;
    assign st1_approx    = 1'b0;
    assign st2_approx    = 1'b0;
`endif

    always_comb begin
        for (int n = 0; n < 8; n++) col_in[n] = tbuf[rbank][n][col_cnt];
    end

    dct_1d #(
        .IN_W        (SIZE),
        .PROD_W      (SIZE_MULT),
        .OUT_W       (SIZE_OUT),
        .APPROX_BITS (APPROX_BITS_ST1)
    ) u_row (
        .x      (data_in),
        .approx (st1_approx),
        .y      (row_res)
    );

    dct_1d #(
        .IN_W        (SIZE_OUT),
        .PROD_W      (SIZE_MULT2),
        .OUT_W       (SIZE_FINAL),
        .APPROX_BITS (APPROX_BITS_ST2)
    ) u_col (
        .x      (col_in),
        .approx (st2_approx),
        .y      (col_res)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fill_act <= 1'b0;
            col_act  <= 1'b0;
            wbank    <= 1'b0;
            rbank    <= 1'b0;
            row_cnt  <= 3'd0;
            col_cnt  <= 3'd0;
            dct_done <= 1'b0;
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < 8; r++)
                    for (int c = 0; c < 8; c++) tbuf[b][r][c] <= '0;
            for (int u = 0; u < 8; u++)
                for (int v = 0; v < 8; v++) begin
                    shadow[u][v]   <= '0;
                    data_out[u][v] <= '0;
                end
        end else begin
            dct_done <= 1'b0;
            if (col_act) begin
                for (int u = 0; u < 8; u++) shadow[u][col_cnt] <= saturate(col_res[u]);
                col_cnt <= col_cnt + 3'd1;
                if (col_cnt == 3'd7) begin
                    col_act  <= 1'b0;
                    dct_done <= 1'b1;
                    for (int u = 0; u < 8; u++) begin
                        for (int v = 0; v < 7; v++) data_out[u][v] <= shadow[u][v];
                        data_out[u][7] <= saturate(col_res[u]);
                    end
                end
            end
            // Placed after the column stage so a back-to-back launch wins at E15.
            if (wr) begin
                for (int n = 0; n < 8; n++) tbuf[wbank][row_cnt][n] <= row_res[n];
                row_cnt  <= row_cnt + 3'd1;
                fill_act <= 1'b1;
                if (launch) begin
                    fill_act <= 1'b0;
                    wbank    <= ~wbank;
                    rbank    <= wbank;
                    col_act  <= 1'b1;
                    col_cnt  <= 3'd0;
                end
            end
        end
    end

endmodule

// File: tb/tb_dct_2d_top.sv
// Randomised self-checking bench for dct_2d_top against a real-arithmetic DCT reference model.
// Honours DCT_APPROX_EN to decide whether approx_en is expected to take effect.
module tb_dct_2d_top;

`ifdef DCT_APPROX_EN
    localparam bit APX_ON = 1'b1;
`else
    localparam bit APX_ON = 1'b0;
`endif
    localparam real PI = 3.14159265358979;

    logic               clk = 1'b0;
    logic               rst;
    logic               dct_en;
    logic signed [7:0]  data_in [8];
    logic [1:0]         approx_en;
    logic signed [10:0] data_out [8][8];
    logic               dct_done;

    int coef [8][8];
    int mdl [8][8];
    int blk [8][8];
    int e0_q [$];
    int exp_q [$];
    int cyc = 0;
    int errors = 0;
    int checks = 0;
    int last_seen = 0;

    dct_2d_top dut (
        .clk       (clk),
        .rst       (rst),
        .dct_en    (dct_en),
        .data_in   (data_in),
        .approx_en (approx_en),
        .data_out  (data_out),
        .dct_done  (dct_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int dct1(input int v[8], input int k, input bit apx, input int bits);
        int acc = 32;
        int p;
        for (int n = 0; n < 8; n++) begin
            p = v[n] * coef[k][n];
            if (apx) p = p & ~((1 << bits) - 1);
            acc += p;
        end
        return acc >>> 6;
    endfunction

    function automatic void model(input int x[8][8], input bit [1:0] apx);
        int mid [8][8];
        int col [8];
        int r;
        for (int i = 0; i < 8; i++)
            for (int k = 0; k < 8; k++) mid[i][k] = dct1(x[i], k, apx[0] && APX_ON, 4);
        for (int v = 0; v < 8; v++) begin
            for (int n = 0; n < 8; n++) col[n] = mid[n][v];
            for (int u = 0; u < 8; u++) begin
                r = dct1(col, u, apx[1] && APX_ON, 8);
                if (r > 1023) r = 1023;
                if (r < -1024) r = -1024;
                mdl[u][v] = r;
            end
        end
    endfunction

    task automatic fill(input int val);
        for (int r = 0; r < 8; r++)
            for (int n = 0; n < 8; n++) blk[r][n] = val;
    endtask

    task automatic fill_rand();
        for (int r = 0; r < 8; r++)
            for (int n = 0; n < 8; n++) blk[r][n] = int'($urandom_range(0, 255)) - 128;
    endtask

    // Drives rows on successive negedges; approx_en is scrambled after E0 to prove it is held.
    task automatic send(input int rows[8][8], input bit [1:0] apx, input bit en_all,
                        input int nrows);
        for (int r = 0; r < nrows; r++) begin
            @(negedge clk);
            dct_en    = (r == 0) || en_all;
            approx_en = (r == 0) ? apx : 2'($urandom);
            for (int n = 0; n < 8; n++) data_in[n] = 8'(rows[r][n]);
            if (r == 0 && nrows == 8) e0_q.push_back(cyc + 1);
        end
        if (nrows == 8) begin
            model(rows, apx);
            for (int u = 0; u < 8; u++)
                for (int v = 0; v < 8; v++) exp_q.push_back(mdl[u][v]);
        end
    endtask

    task automatic end_stream();
        @(negedge clk);
        dct_en = 1'b0;
    endtask

    task automatic check_block(input string name, input bit dc_chk, input int dc_exp);
        int seen = -1;
        int e0;
        int ev;
        for (int i = 0; i < 40 && seen < 0; i++) begin
            @(negedge clk);
            if (dct_done) seen = cyc;
        end
        e0 = e0_q.pop_front();
        if (seen < 0) begin
            check_val({name, "_done_timeout"}, 0, 1);
            for (int i = 0; i < 64; i++) ev = exp_q.pop_front();
            return;
        end
        last_seen = seen;
        check_val({name, "_latency"}, seen - e0, 15);
        if (dc_chk) check_val({name, "_dc_const"}, int'(data_out[0][0]), dc_exp);
        for (int u = 0; u < 8; u++)
            for (int v = 0; v < 8; v++) begin
                ev = exp_q.pop_front();
                check_val($sformatf("%s[%0d][%0d]", name, u, v), int'(data_out[u][v]), ev);
            end
        @(negedge clk);
        check_val({name, "_done_pulse"}, int'(dct_done), 0);
    endtask

    initial begin
        int pat [8];
        int d1;
        int cnt;
        pat = '{80, -120, 12, 5, -90, 127, 34, 2};
        for (int k = 0; k < 8; k++)
            for (int n = 0; n < 8; n++) begin
                real ck;
                real rv;
                ck = (k == 0) ? 1.0 / $sqrt(2.0) : 1.0;
                rv = 32.0 * ck * $cos(real'((2 * n + 1) * k) * PI / 16.0);
                coef[k][n] = (rv >= 0.0) ? $rtoi(rv + 0.5) : -$rtoi(-rv + 0.5);
            end

        rst = 1'b0;
        dct_en = 1'b0;
        approx_en = 2'b00;
        for (int n = 0; n < 8; n++) data_in[n] = '0;
        repeat (3) @(negedge clk);
        check_val("reset_done", int'(dct_done), 0);
        check_val("reset_out00", int'(data_out[0][0]), 0);
        check_val("reset_out35", int'(data_out[3][5]), 0);
        rst = 1'b1;

        fill(16);
        send(blk, 2'b00, 1'b0, 8); end_stream(); check_block("t1_16", 1'b1, 132);
        repeat (5) @(negedge clk);
        check_val("t1_hold", int'(data_out[0][0]), 132);

        fill(17);
        send(blk, 2'b00, 1'b0, 8); end_stream(); check_block("t2_17", 1'b1, 141);
        send(blk, 2'b01, 1'b0, 8); end_stream(); check_block("t2_17apx", 1'b1, APX_ON ? 138 : 141);

        fill(-128);
        send(blk, 2'b00, 1'b0, 8); end_stream(); check_block("t3_neg", 1'b1, -1024);
        fill(127);
        send(blk, 2'b00, 1'b0, 8); end_stream(); check_block("t3_pos", 1'b1, 1023);

        // dct_en held high through E1..E7 must not restart the block
        fill_rand();
        send(blk, 2'b11, 1'b1, 8); end_stream(); check_block("en_hold", 1'b0, 0);
        cnt = 0;
        repeat (20) begin @(negedge clk); if (dct_done) cnt++; end
        check_val("en_hold_extra_done", cnt, 0);

        fork
            begin
                fill(16); send(blk, 2'b00, 1'b0, 8);
                fill(0);  send(blk, 2'b00, 1'b0, 8);
                end_stream();
            end
            begin
                check_block("t4_a", 1'b1, 132);
                d1 = last_seen;
                check_block("t4_b", 1'b1, 0);
                check_val("t4_spacing", last_seen - d1, 8);
            end
        join

        for (int r = 0; r < 8; r++)
            for (int n = 0; n < 8; n++) blk[r][n] = pat[n];
        send(blk, 2'b10, 1'b0, 8); end_stream(); check_block("t6_row", 1'b0, 0);

        for (int i = 0; i < 3; i++) begin
            fork
                begin
                    fill_rand(); send(blk, 2'($urandom), 1'b0, 8);
                    fill_rand(); send(blk, 2'($urandom), 1'b0, 8);
                    end_stream();
                end
                begin
                    check_block($sformatf("rnd%0da", i), 1'b0, 0);
                    check_block($sformatf("rnd%0db", i), 1'b0, 0);
                end
            join
        end

        // Abort a block with reset asserted just before E4
        fill_rand();
        send(blk, 2'b00, 1'b0, 4);
        @(negedge clk);
        rst = 1'b0;
        dct_en = 1'b0;
        @(negedge clk);
        check_val("t5_done_in_rst", int'(dct_done), 0);
        for (int u = 0; u < 8; u++)
            for (int v = 0; v < 8; v++)
                check_val($sformatf("t5_clr[%0d][%0d]", u, v), int'(data_out[u][v]), 0);
        @(negedge clk);
        rst = 1'b1;
        cnt = 0;
        repeat (25) begin @(negedge clk); if (dct_done) cnt++; end
        check_val("t5_no_done", cnt, 0);
        fill_rand();
        send(blk, 2'($urandom), 1'b0, 8); end_stream(); check_block("t5_after", 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
